led_blink_seq: RTL and testbench
================================

LED_BLINK_SEQ -- requirements
Module: led_blink_seq

Interface
Parameters:
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the half-period tick count.
REQ-002 The block SHALL have parameter BURST_W, default 4, giving the width of the burst blink count.
Ports:
REQ-003 The block SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1, the reset, asynchronous and active-low.
REQ-005 The block SHALL have port Tick, input, 1, a one-Clk-wide time-base pulse from the upstream frequency divider.
REQ-006 The block SHALL have port Mode, input, 2, where 00=OFF, 01=ON, 10=BLINK (continuous) and 11=BURST.
REQ-007 The block SHALL have port HalfPeriod, input, CNT_W, giving the on-phase and off-phase length in Tick pulses.
REQ-008 The block SHALL have port BurstCount, input, BURST_W, giving the number of blinks per BURST run.
REQ-009 The block SHALL have port Start, input, 1, a one-cycle request that launches a BURST run.
REQ-010 The block SHALL have port LED, output, 1, the registered LED drive.
REQ-011 The block SHALL have port Busy, output, 1, high whenever the FSM is not in IDLE.
REQ-012 The block SHALL have port Done, output, 1, a one-cycle pulse when a BURST run completes.

Function
REQ-013 FSM states SHALL be IDLE, ON_PH and OFF_PH; LED=1 exactly in ON_PH, in IDLE with Mode=01, and 0 otherwise.
REQ-014 LED, Busy and Done SHALL all be registered outputs, taking effect on the Clk edge that follows the qualifying input condition.
REQ-015 Mode=00 or 01: FSM SHALL stay in IDLE; LED=0 or 1 respectively; Tick and Start are ignored.
REQ-016 Mode=10 in IDLE: next edge -> ON_PH with tick counter cleared and HalfPeriod latched into an internal register (HP_q).
REQ-017 In ON_PH/OFF_PH the tick counter SHALL increment only on cycles with Tick=1.
REQ-018 A Tick that arrives when the counter equals HP_q-1 SHALL clear the counter and switch phase ON_PH<->OFF_PH on that edge.
REQ-019 HalfPeriod=0 SHALL be latched as 1, so each phase lasts one Tick; the counter never wraps.
REQ-020 Mode=11: IDLE -> ON_PH on Start=1 with BurstCount!=0; BurstCount latches into the remaining-blink register REM_q and HalfPeriod into HP_q.
REQ-021 BURST: on each OFF_PH->phase-end edge, if REM_q==1 -> IDLE with Done=1 for one cycle; otherwise REM_q decrements and the FSM returns to ON_PH.
REQ-022 Start with Mode=11 and BurstCount==0 SHALL produce Done=1 on the next edge while the FSM stays in IDLE and LED stays 0.
REQ-023 Start while Busy=1 SHALL be ignored, as SHALL Start in any Mode other than 11.
REQ-024 Any change of Mode while Busy (registered Mode_q != Mode) SHALL force IDLE on the next edge, clearing counters, with LED per the new Mode and no Done.
REQ-025 If Tick and a Mode change occur in the same cycle, the Mode change SHALL win.
REQ-026 HalfPeriod and BurstCount changes SHALL take effect only at the next IDLE->ON_PH entry.

Reset
REQ-027 Rst=0 SHALL asynchronously force IDLE, with LED=0, Busy=0, Done=0, counter=0, REM_q=0, HP_q=1 and Mode_q=00.
REQ-028 Reset asserted mid-run SHALL abort it with no Done pulse; after release the block SHALL act on Mode from the first edge.

Verification
REQ-029 Mode=10, HalfPeriod=3, Tick every 4 clocks -> LED high for 3 Ticks, low for 3 Ticks, repeating; Busy=1 throughout.
REQ-030 Mode=11, BurstCount=2, HalfPeriod=1, Start pulse -> exactly 2 LED high pulses, then Done=1 for 1 cycle and Busy=0.
REQ-031 Mode=11, BurstCount=0, Start -> Done=1 on the next cycle, LED=0 and Busy=0 throughout.
REQ-032 BURST run in progress, Start re-pulsed, then Mode switched to 01 -> the second Start has no effect; next edge gives IDLE, LED=1, Busy=0, no Done.
REQ-033 Mode=10, HalfPeriod=0 -> LED toggles on every Tick.
REQ-034 Rst pulsed low asynchronously between edges while in ON_PH -> LED=0 and Busy=0 immediately; no Done; BLINK restarts after release.

Source files
------------

// File: rtl/led_blink_seq_if.sv
// Control/status bundle for led_blink_seq: mode and timing inputs, LED drive and run status.
interface led_blink_seq_if #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned BURST_W = 4
);
    logic               Tick;
    logic [1:0]         Mode;
    logic [CNT_W-1:0]   HalfPeriod;
    logic [BURST_W-1:0] BurstCount;
    logic               Start;
    logic               LED;
    logic               Busy;
    logic               Done;

    modport master (
        output Tick, Mode, HalfPeriod, BurstCount, Start,
        input  LED, Busy, Done
    );

    modport slave (
        input  Tick, Mode, HalfPeriod, BurstCount, Start,
        output LED, Busy, Done
    );
endinterface

// File: rtl/led_blink_seq.sv
// LED driver: steady off/on, continuous blink, or a counted burst of blinks paced by Tick.
module led_blink_seq #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned BURST_W = 4
) (
    input logic           Clk,
    input logic           Rst,
    led_blink_seq_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StOnPh, StOffPh} state_e;

    localparam logic [1:0] ModeOff   = 2'b00;
    localparam logic [1:0] ModeOn    = 2'b01;
    localparam logic [1:0] ModeBlink = 2'b10;
    localparam logic [1:0] ModeBurst = 2'b11;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   hp_q;
    logic [BURST_W-1:0] rem_q;
    logic [1:0]         mode_q;
    logic               led_q;
    logic               busy_q;
    logic               done_q;

    logic               phase_end;
    logic [CNT_W-1:0]   hp_latch;

    assign phase_end = bus.Tick && (cnt_q == hp_q - 1'b1);
    // Zero half-period is treated as one Tick so the counter can never wrap.
    assign hp_latch  = (bus.HalfPeriod == '0) ? CNT_W'(1) : bus.HalfPeriod;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hp_q    <= CNT_W'(1);
            rem_q   <= '0;
            mode_q  <= ModeOff;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mode_q <= bus.Mode;
            done_q <= 1'b0;
            // A mode change mid-run aborts silently and outranks any Tick this cycle.
            if (state_q != StIdle && (bus.Mode != mode_q || !bus.Mode[1])) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                rem_q   <= '0;
                busy_q  <= 1'b0;
                led_q   <= (bus.Mode == ModeOn);
            end else begin
                unique case (state_q)
                    StIdle: begin
                        led_q  <= (bus.Mode == ModeOn);
                        busy_q <= 1'b0;
                        if (bus.Mode == ModeBlink) begin
                            state_q <= StOnPh;
                            cnt_q   <= '0;
                            hp_q    <= hp_latch;
                            led_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end else if (bus.Mode == ModeBurst && bus.Start) begin
                            if (bus.BurstCount != '0) begin
                                state_q <= StOnPh;
                                cnt_q   <= '0;
                                hp_q    <= hp_latch;
                                rem_q   <= bus.BurstCount;
                                led_q   <= 1'b1;
                                busy_q  <= 1'b1;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    StOnPh: begin
                        if (phase_end) begin
                            state_q <= StOffPh;
                            cnt_q   <= '0;
                            led_q   <= 1'b0;
                        end else if (bus.Tick) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StOffPh: begin
                        if (phase_end) begin
                            cnt_q <= '0;
                            if (bus.Mode == ModeBurst && rem_q == BURST_W'(1)) begin
                                state_q <= StIdle;
                                rem_q   <= '0;
                                busy_q  <= 1'b0;
                                led_q   <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                if (bus.Mode == ModeBurst) begin
                                    rem_q <= rem_q - 1'b1;
                                end
                                state_q <= StOnPh;
                                led_q   <= 1'b1;
                            end
                        end else if (bus.Tick) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        led_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.LED  = led_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
endmodule

// File: tb/tb_led_blink_seq.sv
// Directed bench for led_blink_seq: steady modes, blink, burst, aborts and async reset.
module tb_led_blink_seq;
    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    led_blink_seq_if #(.CNT_W(8), .BURST_W(4)) bus ();

    led_blink_seq #(.CNT_W(8), .BURST_W(4)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One Tick pulse, sampled just after the edge that consumes it.
    task automatic tick_step();
        bus.Tick = 1'b1;
        step();
        bus.Tick = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic led, input logic busy, input logic done);
        chk({tag, ".led"},  {7'd0, bus.LED},  {7'd0, led});
        chk({tag, ".busy"}, {7'd0, bus.Busy}, {7'd0, busy});
        chk({tag, ".done"}, {7'd0, bus.Done}, {7'd0, done});
    endtask

    initial begin
        logic [11:0] blink_exp;
        logic [3:0]  hp0_exp;
        blink_exp = 12'b1000_1110_0011;  // bit i = LED after tick i+1, HalfPeriod=3
        hp0_exp   = 4'b1010;             // bit i = LED after tick i+1, HalfPeriod=0

        bus.Tick       = 1'b0;
        bus.Mode       = 2'b00;
        bus.HalfPeriod = 8'd3;
        bus.BurstCount = 4'd0;
        bus.Start      = 1'b0;

        #2;
        chk3("reset", 1'b0, 1'b0, 1'b0);
        step();
        Rst = 1'b1;
        step();
        chk3("off_idle", 1'b0, 1'b0, 1'b0);

        // Steady on; Start is ignored outside burst mode
        bus.Mode  = 2'b01;
        bus.Start = 1'b1;
        bus.BurstCount = 4'd2;
        step();
        bus.Start = 1'b0;
        chk3("on_idle", 1'b1, 1'b0, 1'b0);

        // Continuous blink, HalfPeriod=3, Tick every 4 clocks
        bus.Mode = 2'b10;
        step();
        chk3("blink_entry", 1'b1, 1'b1, 1'b0);
        bus.HalfPeriod = 8'd5;  // must not affect the run in progress
        for (int i = 0; i < 12; i++) begin
            tick_step();
            chk($sformatf("blink_tick%0d.led", i + 1), {7'd0, bus.LED}, {7'd0, blink_exp[i]});
            idle_steps(3);
            chk($sformatf("blink_hold%0d.led", i + 1), {7'd0, bus.LED}, {7'd0, blink_exp[i]});
            chk($sformatf("blink_tick%0d.busy", i + 1), {7'd0, bus.Busy}, 8'd1);
        end

        bus.Mode = 2'b00;
        step();
        chk3("blink_abort_off", 1'b0, 1'b0, 1'b0);

        // HalfPeriod=0 behaves as one Tick per phase
        bus.HalfPeriod = 8'd0;
        bus.Mode = 2'b10;
        step();
        chk3("hp0_entry", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick_step();
            chk($sformatf("hp0_tick%0d.led", i + 1), {7'd0, bus.LED}, {7'd0, hp0_exp[i]});
            idle_steps(1);
        end

        // Tick and mode change together: mode change wins
        bus.Tick = 1'b1;
        bus.Mode = 2'b01;
        step();
        bus.Tick = 1'b0;
        chk3("tick_vs_mode", 1'b1, 1'b0, 1'b0);

        // Burst of 2, HalfPeriod=1
        bus.Mode = 2'b11;
        step();
        chk3("burst_idle", 1'b0, 1'b0, 1'b0);
        bus.HalfPeriod = 8'd1;
        bus.BurstCount = 4'd2;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        chk3("burst_on1", 1'b1, 1'b1, 1'b0);
        idle_steps(2);
        tick_step();
        chk3("burst_off1", 1'b0, 1'b1, 1'b0);
        tick_step();
        chk3("burst_on2", 1'b1, 1'b1, 1'b0);
        tick_step();
        chk3("burst_off2", 1'b0, 1'b1, 1'b0);
        tick_step();
        chk3("burst_done", 1'b0, 1'b0, 1'b1);
        step();
        chk3("burst_after", 1'b0, 1'b0, 1'b0);

        // Burst count zero: immediate Done, no run
        bus.BurstCount = 4'd0;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        chk3("burst0_done", 1'b0, 1'b0, 1'b1);
        step();
        chk3("burst0_after", 1'b0, 1'b0, 1'b0);

        // Restart ignored while busy, then mode switch aborts without Done
        bus.BurstCount = 4'd3;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        chk3("b3_on", 1'b1, 1'b1, 1'b0);
        tick_step();
        chk3("b3_off", 1'b0, 1'b1, 1'b0);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        chk3("b3_restart_ignored", 1'b0, 1'b1, 1'b0);
        bus.Mode = 2'b01;
        step();
        chk3("b3_abort_on", 1'b1, 1'b0, 1'b0);
        step();
        chk3("b3_abort_after", 1'b1, 1'b0, 1'b0);

        // Async reset between edges while in ON_PH
        bus.HalfPeriod = 8'd2;
        bus.Mode = 2'b10;
        step();
        chk3("rst_pre", 1'b1, 1'b1, 1'b0);
        #3;
        Rst = 1'b0;
        #1;
        chk3("rst_async", 1'b0, 1'b0, 1'b0);
        #1;
        Rst = 1'b1;
        step();
        chk3("rst_restart", 1'b1, 1'b1, 1'b0);
        tick_step();
        chk3("rst_tick1", 1'b1, 1'b1, 1'b0);
        tick_step();
        chk3("rst_tick2", 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
